// File: rtl/addr_scan_pkg.sv
// Shared types and constants for the address scan sequencer and its prescaler.
package addr_scan_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DIV_W_DEF  = 8;

  // Scan direction encodings for the DIR input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Down-counter with reload: raises TICK for one cycle every DIV+1 enabled cycles.
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             RELOAD,
  input  logic [DIV_W-1:0] DIV,
  output logic             TICK
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // The tick fires on the cycle the enabled count has run down to zero.
  assign TICK = EN && (count_q == CNT_ZERO);

  // Next count: reload on start, otherwise count down and reload after each tick.
  always_comb begin
    count_d = count_q;
    if (RELOAD) begin
      count_d = DIV;
    end else if (EN) begin
      if (count_q == CNT_ZERO) begin
        count_d = DIV;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/addr_scan_sequencer.sv
// Steps an address through a captured window [LO, HI] at a prescaled rate,
// one-shot or wrapping, and feeds it to the downstream 4-to-16 decoder.
module addr_scan_sequencer
  import addr_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [ADDR_W-1:0] LO,
  input  logic [ADDR_W-1:0] HI,
  input  logic              DIR,
  input  logic              CONT,
  input  logic [DIV_W-1:0]  DIV,
  output logic [ADDR_W-1:0] ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              WRAP,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic              dir_q, dir_d;
  logic              cont_q, cont_d;
  logic [DIV_W-1:0]  div_q, div_d;

  logic              start_accept_s;
  logic              tick_s;
  logic [DIV_W-1:0]  presc_div_s;
  logic [ADDR_W-1:0] end_addr_s;
  logic [ADDR_W-1:0] begin_addr_s;

  // STOP beats START, and an inverted window is never accepted.
  assign start_accept_s = (state_q == IDLE) && START && !STOP && (LO <= HI);

  // On the start cycle the prescaler loads the live DIV; afterwards the shadow copy.
  assign presc_div_s  = start_accept_s ? DIV : div_q;
  assign end_addr_s   = (dir_q == DIR_DOWN) ? lo_q : hi_q;
  assign begin_addr_s = (dir_q == DIR_DOWN) ? hi_q : lo_q;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (state_q == RUN),
    .RELOAD (start_accept_s),
    .DIV    (presc_div_s),
    .TICK   (tick_s)
  );

  // Next-state and output decode for the IDLE/RUN scan controller.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (start_accept_s) begin
          lo_d    = LO;
          hi_d    = HI;
          dir_d   = DIR;
          cont_d  = CONT;
          div_d   = DIV;
          addr_d  = (DIR == DIR_DOWN) ? HI : LO;
          busy_d  = 1'b1;
          state_d = RUN;
        end else if (START && !STOP) begin
          // Only reachable with LO > HI: reject and keep the address.
          err_d = 1'b1;
        end else begin
          addr_d = addr_q;
        end
      end
      RUN: begin
        if (STOP) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tick_s) begin
          if (addr_q == end_addr_s) begin
            if (cont_q) begin
              addr_d = begin_addr_s;
              wrap_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (dir_q == DIR_DOWN) begin
            addr_d = addr_q - ADDR_ONE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, address, status pulses and shadow window registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= ADDR_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= ADDR_ZERO;
      hi_q    <= ADDR_ZERO;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      div_q   <= {DIV_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      div_q   <= div_d;
    end
  end

  assign ADDR = addr_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_addr_scan_sequencer.sv
// Scoreboard bench: each scenario queues the per-cycle outputs it expects
// ({ADDR, BUSY, DONE, WRAP, ERR}) and the sampler pops and compares them.
module tb_addr_scan_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       STOP;
  logic [3:0] LO;
  logic [3:0] HI;
  logic       DIR;
  logic       CONT;
  logic [7:0] DIV;
  logic [3:0] ADDR;
  logic       BUSY;
  logic       DONE;
  logic       WRAP;
  logic       ERR;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  addr_scan_sequencer dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .STOP  (STOP),
    .LO    (LO),
    .HI    (HI),
    .DIR   (DIR),
    .CONT  (CONT),
    .DIV   (DIV),
    .ADDR  (ADDR),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .WRAP  (WRAP),
    .ERR   (ERR)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic exp_push(input logic [3:0] a, input logic b, input logic d,
                          input logic w, input logic e);
    exp_q.push_back({a, b, d, w, e});
  endtask

  // Pop one expected vector and compare with the live outputs {ADDR,BUSY,DONE,WRAP,ERR}.
  task automatic sample(input string tag);
    logic [7:0] want;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      check_eq(tag, 32'({ADDR, BUSY, DONE, WRAP, ERR}), 32'(want));
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    #1;
    sample(tag);
  endtask

  initial begin
    logic [15:0] dec;
    logic [3:0]  a;
    RST = 1'b1; START = 1'b0; STOP = 1'b0;
    LO = 4'd0; HI = 4'd0; DIR = 1'b0; CONT = 1'b0; DIV = 8'd0;

    // Reset state.
    #12;
    exp_push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0); sample("reset");
    exp_push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("reset_hold");
    RST = 1'b0;
    exp_push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("idle_after_reset");

    // Reset in the middle of a scan.
    LO = 4'd2; HI = 4'd9; DIV = 8'd0; START = 1'b1;
    exp_push(4'd2, 1'b1, 1'b0, 1'b0, 1'b0); step("rst_mid_start");
    START = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_push(4'(2 + i), 1'b1, 1'b0, 1'b0, 1'b0); step("rst_mid_run");
    end
    #1 RST = 1'b1;
    #1;
    exp_push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0); sample("rst_mid_async");
    #1 RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("rst_mid_nodone");
    end

    // One-shot full-range scan up.
    LO = 4'd0; HI = 4'd15; DIR = 1'b0; CONT = 1'b0; DIV = 8'd0; START = 1'b1;
    exp_push(4'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("up_start");
    START = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      exp_push(4'(i), 1'b1, 1'b0, 1'b0, 1'b0); step("up_run");
    end
    exp_push(4'd15, 1'b0, 1'b1, 1'b0, 1'b0); step("up_done");
    exp_push(4'd15, 1'b0, 1'b0, 1'b0, 1'b0); step("up_idle");
    exp_push(4'd15, 1'b0, 1'b0, 1'b0, 1'b0); step("up_idle2");

    // Continuous down with prescale; live inputs change after START and must be ignored.
    LO = 4'd3; HI = 4'd5; DIR = 1'b1; CONT = 1'b1; DIV = 8'd2; START = 1'b1;
    exp_push(4'd5, 1'b1, 1'b0, 1'b0, 1'b0); step("cont_start");
    START = 1'b0; LO = 4'd0; HI = 4'd15; DIR = 1'b0; CONT = 1'b0; DIV = 8'd0;
    for (int e = 1; e <= 20; e++) begin
      a = 4'(5 - ((e / 3) % 3));
      exp_push(a, 1'b1, 1'b0, (e % 9) == 0, 1'b0); step("cont_run");
    end
    // Edge 21 would be a tick to 4; STOP must win and hold 5.
    STOP = 1'b1;
    exp_push(4'd5, 1'b0, 1'b0, 1'b0, 1'b0); step("cont_stop_on_tick");
    STOP = 1'b0;
    exp_push(4'd5, 1'b0, 1'b0, 1'b0, 1'b0); step("cont_stopped");

    // STOP colliding with a tick at ADDR=7, then START+STOP together from IDLE.
    LO = 4'd0; HI = 4'd15; DIR = 1'b0; CONT = 1'b0; DIV = 8'd0; START = 1'b1;
    exp_push(4'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("coll_start");
    START = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      exp_push(4'(i), 1'b1, 1'b0, 1'b0, 1'b0); step("coll_run");
    end
    STOP = 1'b1;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("coll_stop");
    STOP = 1'b0;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("coll_idle");
    START = 1'b1; STOP = 1'b1;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("start_stop_same");
    START = 1'b0; STOP = 1'b0;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("start_stop_after");

    // Rejected inverted window.
    LO = 4'd9; HI = 4'd4; START = 1'b1;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b1); step("err_pulse");
    START = 1'b0;
    exp_push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("err_clear");

    // Single-address window with prescale; downstream decoder sees bit 6.
    LO = 4'd6; HI = 4'd6; DIR = 1'b0; CONT = 1'b0; DIV = 8'd3; START = 1'b1;
    exp_push(4'd6, 1'b1, 1'b0, 1'b0, 1'b0); step("single_start");
    START = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_push(4'd6, 1'b1, 1'b0, 1'b0, 1'b0); step("single_run");
      dec = 16'h0001 << ADDR;
      check_eq("single_dec", 32'(dec), 32'h0000_0040);
    end
    exp_push(4'd6, 1'b0, 1'b1, 1'b0, 1'b0); step("single_done");
    exp_push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0); step("single_idle");

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addr_scan_sequencer.md
Name: addr_scan_sequencer

Overview:
- Clocked address generator directly upstream of dec_4_to_16; its ADDR output drives the decoder's ADDR input.
- Steps a 4-bit address through a programmable window [LO, HI], up or down, at a prescaled rate.
- Runs in one-shot or continuous (wrap) mode, with start/stop control and status pulses.
- Replaces the open-loop address stimulus with synthesizable scan logic for display/row-select use.

Parameters:
- ADDR_W, 4, address width; must match the decoder input width.
- DIV_W, 8, width of the prescaler reload value.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  level sampled each edge; starts a scan from IDLE.
- STOP  input  1  level sampled each edge; aborts a scan.
- LO  input  ADDR_W  lower window bound, captured on accepted START.
- HI  input  ADDR_W  upper window bound, captured on accepted START.
- DIR  input  1  0 = count up LO→HI, 1 = count down HI→LO; captured on START.
- CONT  input  1  1 = wrap continuously, 0 = one-shot; captured on START.
- DIV  input  DIV_W  prescaler reload; address advances every DIV+1 cycles; captured on START.
- ADDR  output  ADDR_W  current address to the decoder.
- BUSY  output  1  high while scanning (RUN state).
- DONE  output  1  one-cycle pulse when a one-shot scan completes.
- WRAP  output  1  one-cycle pulse when a continuous scan wraps.
- ERR  output  1  one-cycle pulse when START is rejected.

Behaviour:
- Clocking and reset: one clock, CLK. RST is asynchronous, active-high.
- Reset values: ADDR=0, BUSY=0, DONE=0, WRAP=0, ERR=0, state=IDLE, prescaler count=0, shadow registers=0.
- RST mid-scan: scan aborts immediately; outputs take reset values; no DONE pulse.
- All outputs are registered; pulse outputs are high for exactly one cycle.

State machine (IDLE, RUN):
- IDLE, START=1, STOP=0, LO<=HI:
  - capture LO/HI/DIR/CONT/DIV into shadow registers;
  - ADDR <= (DIR ? HI : LO); count <= DIV; BUSY <= 1; next state RUN.
  - Latency: START sampled at edge k gives BUSY=1 and the start address after edge k.
- IDLE, START=1, LO>HI: ERR pulse; stay IDLE; ADDR unchanged.
- IDLE, START=1 and STOP=1 in the same cycle: STOP wins; START ignored; no ERR.
- IDLE otherwise: ADDR holds its last value.
- RUN, prescaler:
  - count != 0: count decrements.
  - count == 0: tick; count reloads to DIV. DIV=0 gives a tick every cycle.
- RUN, tick, ADDR is not the end address (HI if up, LO if down): ADDR advances by ±1.
- RUN, tick, ADDR is the end address:
  - CONT=1: ADDR reloads the start address; WRAP pulses; stay RUN.
  - CONT=0: ADDR holds the end address; DONE pulses; BUSY <= 0; next state IDLE.
- RUN, STOP=1: next state IDLE; BUSY <= 0; ADDR holds; no DONE/WRAP. STOP has priority over a same-cycle tick.
- RUN, START=1: ignored. Live LO/HI/DIR/CONT/DIV changes have no effect until the next accepted START.
- Window rules:
  - Arithmetic is within the window only; ADDR never leaves [LO, HI], so there is no 4-bit overflow.
  - LO==HI: one address; the end is reached on the first tick.
- One-shot timing: accepted START at edge k gives DONE high after edge k + (HI-LO+1)*(DIV+1).

Decomposition:
- Package addr_scan_pkg: state enum type (IDLE, RUN), ADDR_W/DIV_W defaults, DIR_UP/DIR_DOWN constants.
- One sub-module: tick_prescaler (CLK, RST, EN, RELOAD, DIV → TICK), a down-counter with reload. All other logic stays in the top-level FSM.

Test Plan:
- Reset mid-scan: LO=2, HI=9, DIV=0, START, assert RST at cycle 4 → ADDR=0, BUSY=0 immediately; no DONE.
- One-shot up: LO=0, HI=15, DIR=0, CONT=0, DIV=0, START at edge 0 → ADDR 0..15 on consecutive cycles; DONE one cycle after edge 16; ADDR stays 15; BUSY low.
- Continuous down with prescale: LO=3, HI=5, DIR=1, CONT=1, DIV=2 → ADDR 5,5,5,4,4,4,3,3,3,5…; WRAP pulses each time ADDR returns to 5; BUSY stays 1.
- STOP/tick collision: DIV=0, STOP asserted on a cycle where ADDR=7 → IDLE with ADDR=7; no DONE; same-cycle START+STOP from IDLE → no start.
- Rejected window: LO=9, HI=4, START → ERR single pulse; BUSY=0; ADDR unchanged.
- Single-address window: LO=HI=6, CONT=0, DIV=3 → ADDR=6; DONE after edge 4; a downstream dec_4_to_16 shows DEC=16'h0040 throughout.
